rv_decode_buffer: RTL and testbench
===================================

Name: rv_decode_buffer

Overview:
- Parametrised RV32 instruction pre-decode stage between fetch and issue.
- Classifies each 32-bit instruction by major opcode: LOAD, STORE, JAL, LUI, SYSTEM, JALR, AUIPC, BRANCH, OP-IMM, OP, AMO.
- Extracts register indices and the sign-extended immediate; flags illegal and disabled-extension encodings.
- Holds decoded entries in a small ready/valid FIFO so fetch and issue decouple at full throughput.

Parameters:
- DEPTH, 2, FIFO entries; power of two, at least 2.
- ENABLE_ATOMIC, 1, when 0, opcode 0101111 decodes as illegal.
- ENABLE_MUL, 1, when 0, OP with funct7=0000001 decodes as illegal.
- ENABLE_CSR, 1, when 0, SYSTEM with funct3!=000 decodes as illegal.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- flush  in  1  discard all buffered entries and the current input.
- in_valid  in  1  fetch holds an instruction.
- in_ready  out  1  buffer can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  32  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  issue consumes the head.
- out_instr  out  32  raw instruction of the head entry.
- out_pc  out  32  PC of the head entry.
- out_class  out  4  0 LOAD, 1 STORE, 2 JAL, 3 LUI, 4 SYSTEM, 5 JALR, 6 AUIPC, 7 BRANCH, 8 OP-IMM, 9 OP, 10 AMO, 15 ILLEGAL.
- out_rd  out  5  destination register.
- out_rs1  out  5  source register 1.
- out_rs2  out  5  source register 2.
- out_imm  out  32  decoded immediate.
- out_illegal  out  1  head entry is illegal.
- illegal_count  out  CNT_W  saturating count of illegal entries consumed.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - FIFO empty; out_valid=0; in_ready=1; illegal_count=0.
  - out_instr=0x00000033 (NOP); out_pc=0; out_class=9; rd/rs1/rs2/imm=0; out_illegal=0.
- Handshakes:
  - Push when in_valid&&in_ready.
  - Pop when out_valid&&out_ready.
  - in_ready = (count!=DEPTH).
  - out_valid = (count!=0).
  - in_ready does not depend on out_ready, so there is no combinational path.
- Latency: an instruction accepted at edge k is presented with out_valid=1 after edge k (one cycle). Decode is combinational before the FIFO write; outputs come straight from registered FIFO storage.
- Throughput: simultaneous push and pop keep count unchanged; one instruction per cycle in steady state.
- Ordering: strict FIFO. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Illegal decode (out_class=15, out_illegal=1, rd forced to 0, imm=0) occurs when any of:
  - in_instr[1:0]!=11;
  - unlisted opcode;
  - disabled extension per the ENABLE_* parameters;
  - OP with funct7 not 0000000 or 0100000 (or 0000001 when ENABLE_MUL=1).
  out_instr keeps the raw bits for trap reporting.
- Immediates, all sign-extended from bit 31:
  - I-type: LOAD, JALR, OP-IMM, SYSTEM.
  - S-type: STORE.
  - B-type: BRANCH; bit 0 = 0.
  - U-type: LUI, AUIPC; low 12 bits = 0.
  - J-type: JAL; bit 0 = 0.
  - OP and AMO: imm=0.
- Register fields: rd/rs1/rs2 always taken from bits 11:7/19:15/24:20, except that rd is forced to 0 for STORE, BRANCH and ILLEGAL.
- Flush:
  - Empties the FIFO (pointers and count to 0) at the next edge.
  - A same-cycle push and a same-cycle pop are both ignored.
  - The counter does not count a flushed-away pop.
  - out_valid=0 the cycle after.
- Output data when the FIFO is empty: out_valid=0 and the fields show the last storage location (don't-care).
- illegal_count: increments by 1 on each pop with out_illegal=1; saturates at 2^CNT_W-1; never wraps; cleared only by reset.
- Reset mid-stream: all state is cleared immediately and asynchronously; no entry survives.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 entries held -> out_valid=0, in_ready=1, out_instr=0x00000033 and illegal_count=0 at once, without waiting for a clock edge.
- Basic decode:
  - push 0x00500093 (addi x1,x0,5) -> next cycle: out_class=8, rd=1, rs1=0, imm=5.
  - push 0x008000EF (jal x1,8) -> class=2, imm=8.
- Store immediate: push 0xFE20AE23 (sw x2,-4(x1)) -> class=1, rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC.
- Backpressure (DEPTH=2): out_ready=0, offer 3 instructions -> first two accepted and in_ready=0 on the third; then raise out_ready -> all three emerge in order, none lost or duplicated.
- Disabled atomics (ENABLE_ATOMIC=0): push 0x0020A02F (amoadd.w) and consume it -> class=15, out_illegal=1, rd=0; illegal_count becomes 1. Push 0x00000000 -> illegal, count becomes 2.
- Flush:
  - 2 entries buffered, and flush=1 together with in_valid=1 and out_ready=1 -> next cycle out_valid=0, count=0, illegal_count unchanged.
  - The next push appears after one cycle.

Source files
------------

// File: rtl/rv_decode_buffer.sv
// RV32 pre-decode stage: classifies each fetched instruction and extracts its operand fields
// before the instruction enters a small ready/valid FIFO that feeds issue.
module rv_decode_buffer #(
  parameter int unsigned DEPTH         = 2,
  parameter bit          ENABLE_ATOMIC = 1'b1,
  parameter bit          ENABLE_MUL    = 1'b1,
  parameter bit          ENABLE_CSR    = 1'b1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [3:0]       out_class,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [31:0]      out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int unsigned  AW      = $clog2(DEPTH);
  localparam logic [AW:0]  LP_FULL = (AW+1)'(DEPTH);

  localparam logic [3:0] C_LOAD   = 4'd0;
  localparam logic [3:0] C_STORE  = 4'd1;
  localparam logic [3:0] C_JAL    = 4'd2;
  localparam logic [3:0] C_LUI    = 4'd3;
  localparam logic [3:0] C_SYSTEM = 4'd4;
  localparam logic [3:0] C_JALR   = 4'd5;
  localparam logic [3:0] C_AUIPC  = 4'd6;
  localparam logic [3:0] C_BRANCH = 4'd7;
  localparam logic [3:0] C_OPIMM  = 4'd8;
  localparam logic [3:0] C_OP     = 4'd9;
  localparam logic [3:0] C_AMO    = 4'd10;
  localparam logic [3:0] C_ILL    = 4'd15;

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [3:0]  w_class;
  logic [31:0] w_imm;
  logic [4:0]  w_rd;
  logic        w_illegal;
  logic        w_push;
  logic        w_pop;

  logic [31:0] r_instr [DEPTH];
  logic [31:0] r_pc    [DEPTH];
  logic [3:0]  r_class [DEPTH];
  logic [4:0]  r_rd    [DEPTH];
  logic [4:0]  r_rs1   [DEPTH];
  logic [4:0]  r_rs2   [DEPTH];
  logic [31:0] r_imm   [DEPTH];
  logic        r_ill   [DEPTH];

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [CNT_W-1:0] r_ill_cnt;

  assign w_op    = in_instr[6:0];
  assign w_f3    = in_instr[14:12];
  assign w_f7    = in_instr[31:25];
  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
  assign w_imm_u = {in_instr[31:12], 12'h000};
  assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

  // Every legal opcode ends in 2'b11, so a compressed encoding falls into the default arm.
  always_comb begin
    w_class = C_ILL;
    w_imm   = 32'h0;
    case (w_op)
      7'b0000011: begin w_class = C_LOAD;   w_imm = w_imm_i; end
      7'b0100011: begin w_class = C_STORE;  w_imm = w_imm_s; end
      7'b1101111: begin w_class = C_JAL;    w_imm = w_imm_j; end
      7'b0110111: begin w_class = C_LUI;    w_imm = w_imm_u; end
      7'b1100111: begin w_class = C_JALR;   w_imm = w_imm_i; end
      7'b0010111: begin w_class = C_AUIPC;  w_imm = w_imm_u; end
      7'b1100011: begin w_class = C_BRANCH; w_imm = w_imm_b; end
      7'b0010011: begin w_class = C_OPIMM;  w_imm = w_imm_i; end
      7'b1110011: begin
        if (ENABLE_CSR || (w_f3 == 3'b000)) begin
          w_class = C_SYSTEM;
          w_imm   = w_imm_i;
        end
      end
      7'b0110011: begin
        if ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000) ||
            (ENABLE_MUL && (w_f7 == 7'b0000001))) begin
          w_class = C_OP;
        end
      end
      7'b0101111: begin
        if (ENABLE_ATOMIC) w_class = C_AMO;
      end
      default: ;
    endcase
  end

  assign w_illegal = (w_class == C_ILL);
  assign w_rd      = (w_illegal || (w_class == C_STORE) || (w_class == C_BRANCH)) ?
                     5'd0 : in_instr[11:7];

  assign in_ready  = (r_count != LP_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  // Storage resets to a decoded NOP so the empty-FIFO outputs are well defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_instr[i] <= 32'h0000_0033;
        r_pc[i]    <= 32'h0;
        r_class[i] <= C_OP;
        r_rd[i]    <= 5'd0;
        r_rs1[i]   <= 5'd0;
        r_rs2[i]   <= 5'd0;
        r_imm[i]   <= 32'h0;
        r_ill[i]   <= 1'b0;
      end
    end else if (w_push) begin
      r_instr[r_wptr] <= in_instr;
      r_pc[r_wptr]    <= in_pc;
      r_class[r_wptr] <= w_class;
      r_rd[r_wptr]    <= w_rd;
      r_rs1[r_wptr]   <= in_instr[19:15];
      r_rs2[r_wptr]   <= in_instr[24:20];
      r_imm[r_wptr]   <= w_imm;
      r_ill[r_wptr]   <= w_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ill_cnt <= '0;
    end else if (w_pop && r_ill[r_rptr] && (r_ill_cnt != '1)) begin
      r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end
  end

  assign out_instr     = r_instr[r_rptr];
  assign out_pc        = r_pc[r_rptr];
  assign out_class     = r_class[r_rptr];
  assign out_rd        = r_rd[r_rptr];
  assign out_rs1       = r_rs1[r_rptr];
  assign out_rs2       = r_rs2[r_rptr];
  assign out_imm       = r_imm[r_rptr];
  assign out_illegal   = r_ill[r_rptr];
  assign illegal_count = r_ill_cnt;

endmodule

// File: tb/tb_rv_decode_buffer.sv
// Scoreboard bench for rv_decode_buffer: expectations are queued at the accepting edge and
// compared field by field when the head is consumed.
module tb_rv_decode_buffer;

  localparam int DEPTH = 2;
  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic [3:0]       out_class;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [31:0]      out_imm;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_count;

  rv_decode_buffer #(
    .DEPTH(DEPTH), .ENABLE_ATOMIC(1'b0), .ENABLE_MUL(1'b1), .ENABLE_CSR(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   ill_model = 0;
  int   pops = 0;
  logic acc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] i, input logic [31:0] pc, input logic [3:0] cls,
                              input logic [4:0] rd, input logic [31:0] imm);
    exp_t e;
    e.instr = i; e.pc = pc; e.cls = cls; e.rd = rd; e.imm = imm; e.ill = (cls == 4'd15);
    return e;
  endfunction

  // Reference decode for this configuration: atomics disabled, MUL and CSR enabled.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [3:0] c;
    logic [31:0] imm;
    c = 4'd15; imm = 32'h0;
    if (i[1:0] == 2'b11) begin
      case (i[6:2])
        5'b00000: begin c = 4'd0; imm = 32'($signed(i[31:20])); end
        5'b01000: begin c = 4'd1; imm = 32'($signed({i[31:25], i[11:7]})); end
        5'b11011: begin c = 4'd2; imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
        5'b01101: begin c = 4'd3; imm = i & 32'hFFFF_F000; end
        5'b11100: begin c = 4'd4; imm = 32'($signed(i[31:20])); end
        5'b11001: begin c = 4'd5; imm = 32'($signed(i[31:20])); end
        5'b00101: begin c = 4'd6; imm = i & 32'hFFFF_F000; end
        5'b11000: begin c = 4'd7; imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
        5'b00100: begin c = 4'd8; imm = 32'($signed(i[31:20])); end
        5'b01100: if (i[31:25] inside {7'h00, 7'h20, 7'h01}) c = 4'd9;
        default: ;
      endcase
    end
    e.instr = i; e.pc = pc; e.cls = c; e.ill = (c == 4'd15);
    e.imm = e.ill ? 32'h0 : imm;
    e.rd  = (c inside {4'd1, 4'd7, 4'd15}) ? 5'd0 : i[11:7];
    return e;
  endfunction

  // One clock cycle: drive at the falling edge, sample 4 ns later, then pass the rising edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input exp_t e, output logic accepted);
    exp_t h;
    int   sz;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #4;
    sz = sb.size();
    accepted = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(sz != 0));
    chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
    chk("illegal_count", 32'(illegal_count), 32'(ill_model));
    if (fl) begin
      sb.delete();
    end else begin
      if (out_valid && ordy && sz != 0) begin
        h = sb.pop_front();
        pops++;
        chk("instr", out_instr, h.instr);
        chk("pc", out_pc, h.pc);
        chk("class", 32'(out_class), 32'(h.cls));
        chk("rd", 32'(out_rd), 32'(h.rd));
        chk("rs1", 32'(out_rs1), 32'(h.instr[19:15]));
        chk("rs2", 32'(out_rs2), 32'(h.instr[24:20]));
        chk("imm", out_imm, h.imm);
        chk("illegal", 32'(out_illegal), 32'(h.ill));
        if (h.ill && ill_model < CNT_MAX) ill_model++;
      end
      if (v && sz < DEPTH) begin
        sb.push_back(e);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc, input logic ordy,
                      input exp_t e);
    cycle(1'b1, ins, pc, ordy, 1'b0, e, acc);
  endtask

  task automatic idle(input logic ordy);
    exp_t d;
    d = mk(32'h0, 32'h0, 4'd0, 5'd0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, ordy, 1'b0, d, acc);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1'b1);
    chk(tag, 32'(sb.size()), 32'd0);
    idle(1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_instr"}, out_instr, 32'h0000_0033);
    chk({tag, "_pc"}, out_pc, 32'h0);
    chk({tag, "_class"}, 32'(out_class), 32'd9);
    chk({tag, "_imm"}, out_imm, 32'h0);
    chk({tag, "_ill"}, 32'(out_illegal), 32'd0);
    chk({tag, "_cnt"}, 32'(illegal_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  ops [13];
    logic [6:0]  f7s [4];
    logic [31:0] ri;
    int          p0;

    ops = '{7'h03, 7'h23, 7'h6F, 7'h37, 7'h73, 7'h67, 7'h17, 7'h63, 7'h13, 7'h33, 7'h2F,
            7'h0B, 7'h12};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h02};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
    out_ready = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decode
    push(32'h0050_0093, 32'h100, 1'b1, mk(32'h0050_0093, 32'h100, 4'd8, 5'd1, 32'd5));
    push(32'h0080_00EF, 32'h104, 1'b1, mk(32'h0080_00EF, 32'h104, 4'd2, 5'd1, 32'd8));
    push(32'hFE20_AE23, 32'h108, 1'b1, mk(32'hFE20_AE23, 32'h108, 4'd1, 5'd0, 32'hFFFF_FFFC));
    push(32'h1234_50B7, 32'h10C, 1'b1, mk(32'h1234_50B7, 32'h10C, 4'd3, 5'd1, 32'h1234_5000));
    push(32'h0020_A02F, 32'h110, 1'b1, mk(32'h0020_A02F, 32'h110, 4'd15, 5'd0, 32'h0));
    push(32'h0000_0000, 32'h114, 1'b1, mk(32'h0000_0000, 32'h114, 4'd15, 5'd0, 32'h0));
    push(32'h0420_80B3, 32'h118, 1'b1, mk(32'h0420_80B3, 32'h118, 4'd15, 5'd0, 32'h0));
    drain("drain_directed");
    chk("cnt_after_directed", 32'(illegal_count), 32'd3);

    // Backpressure: third offer must stall while full, then all three drain in order
    p0 = pops;
    push(32'h0010_0113, 32'h200, 1'b0, model(32'h0010_0113, 32'h200));
    push(32'h0020_0193, 32'h204, 1'b0, model(32'h0020_0193, 32'h204));
    push(32'h0030_0213, 32'h208, 1'b0, model(32'h0030_0213, 32'h208));
    chk("bp_third_stalled", 32'(acc), 32'd0);
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++)
      push(32'h0030_0213, 32'h208, 1'b1, model(32'h0030_0213, 32'h208));
    chk("bp_third_accepted", 32'(acc), 32'd1);
    drain("drain_bp");
    chk("bp_pop_count", 32'(pops - p0), 32'd3);

    // Flush with simultaneous push and pop; the illegal head must not be counted
    push(32'h0000_0000, 32'h300, 1'b0, model(32'h0000_0000, 32'h300));
    push(32'h0050_0093, 32'h304, 1'b0, model(32'h0050_0093, 32'h304));
    cycle(1'b1, 32'h0060_0093, 32'h308, 1'b1, 1'b1, model(32'h0060_0093, 32'h308), acc);
    idle(1'b0);
    push(32'h0070_0093, 32'h30C, 1'b0, model(32'h0070_0093, 32'h30C));
    drain("drain_flush");

    // Illegal counter saturation
    for (int k = 0; k < 8; k++) push(32'h0000_0000, 32'h400 + 32'(4 * k), 1'b1,
                                     model(32'h0000_0000, 32'h400 + 32'(4 * k)));
    drain("drain_sat");
    chk("cnt_saturated", 32'(illegal_count), 32'(CNT_MAX));

    // Random traffic with random backpressure
    for (int k = 0; k < 60; k++) begin
      ri = $urandom;
      ri[6:0] = ops[$urandom_range(0, 12)];
      if (ri[6:0] == 7'h33) ri[31:25] = f7s[$urandom_range(0, 3)];
      cycle(1'($urandom_range(0, 1)), ri, 32'h1000 + 32'(4 * k), 1'($urandom_range(0, 1)),
            1'b0, model(ri, 32'h1000 + 32'(4 * k)), acc);
    end
    drain("drain_random");

    // Asynchronous reset with two entries held
    push(32'h0050_0093, 32'h500, 1'b0, model(32'h0050_0093, 32'h500));
    push(32'h0000_0000, 32'h504, 1'b0, model(32'h0000_0000, 32'h504));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    sb.delete();
    ill_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push(32'h0080_00EF, 32'h600, 1'b1, mk(32'h0080_00EF, 32'h600, 4'd2, 5'd1, 32'd8));
    drain("drain_post_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
